// File: rtl/mux_nch_rr.sv
// N-channel registered mux with valid/ready handshakes, manual or round-robin selection.
// Define MUX_BURST_EN to add in_last/out_last and lock the grant for the length of a burst.
module mux_nch_rr #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
`ifdef MUX_BURST_EN
  input  logic [NCH-1:0]       in_last,
`endif
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
`ifdef MUX_BURST_EN
  output logic                 out_last,
`endif
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_ch_q;
  logic [SELW-1:0]  rr_last_q;

  logic             load;
  logic             xfer;
  logic             target_any;
  logic [SELW-1:0]  target_ch;
  logic [NCH-1:0]   target;
  logic [WIDTH-1:0] pick_data;
  int unsigned      idx;

`ifdef MUX_BURST_EN
  logic             lock_q;
  logic [SELW-1:0]  lock_ch_q;
  logic             out_last_q;
  logic             pick_last;
`endif

  assign load = !out_valid_q || out_ready;

  // The target is the channel offered in_ready; in manual and locked modes it is chosen without
  // looking at that channel's own valid, so ready never depends on valid there.
  always_comb begin
    target_any = 1'b0;
    target_ch  = '0;
    idx        = 0;
`ifdef MUX_BURST_EN
    if (lock_q) begin
      target_any = 1'b1;
      target_ch  = lock_ch_q;
    end else
`endif
    if (!mode) begin
      if (32'(sel) < NCH) begin
        target_any = 1'b1;
        target_ch  = sel;
      end
    end else begin
      for (int unsigned off = 1; off <= NCH; off++) begin
        idx = (32'(rr_last_q) + off) % NCH;
        if (!target_any && in_valid[idx]) begin
          target_any = 1'b1;
          target_ch  = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    target    = '0;
    pick_data = '0;
`ifdef MUX_BURST_EN
    pick_last = 1'b0;
`endif
    for (int unsigned i = 0; i < NCH; i++) begin
      target[i] = target_any && (target_ch == SELW'(i));
      if (target[i]) begin
        pick_data = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_BURST_EN
        pick_last = in_last[i];
`endif
      end
    end
  end

  // Ready is held low during reset so nothing is accepted while the register is cleared.
  assign in_ready = {NCH{rst_n && load}} & target;
  assign xfer     = |(in_ready & in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_last_q   <= SELW'(NCH - 1);
    end else if (load) begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pick_data;
        out_ch_q    <= target_ch;
        if (mode) begin
          rr_last_q <= target_ch;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef MUX_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_ch_q  <= '0;
      out_last_q <= 1'b0;
    end else if (xfer) begin
      lock_q     <= !pick_last;
      lock_ch_q  <= target_ch;
      out_last_q <= pick_last;
    end
  end

  assign out_last = out_last_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nch_rr.sv
// Self-checking bench for mux_nch_rr: a behavioural model checked every cycle plus literal checks.
// Covers the MUX_BURST_EN burst lock when that macro is defined.
module tb_mux_nch_rr;
  localparam int NCH   = 4;
  localparam int WIDTH = 8;
  localparam int SELW  = 3;  // wide enough to drive an out-of-range select

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH-1:0]       in_last;
  logic                 out_last;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_nch_rr #(.NCH(NCH), .WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
`ifdef MUX_BURST_EN
    .in_last  (in_last),
`endif
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_ch   (out_ch),
`ifdef MUX_BURST_EN
    .out_last (out_last),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

`ifndef MUX_BURST_EN
  assign out_last = 1'b0;
`endif

  // Model: what the output register holds, last round-robin winner, and burst lock.
  bit m_valid   = 1'b0;
  int m_data    = 0;
  int m_ch      = 0;
  int m_rr      = NCH - 1;
  bit m_lock    = 1'b0;
  int m_lock_ch = 0;
  bit m_last    = 1'b0;

  function automatic int m_target();
    if (m_lock) return m_lock_ch;
    if (mode == 1'b0) return (int'(sel) < NCH) ? int'(sel) : -1;
    for (int k = 1; k <= NCH; k++) begin
      if (in_valid[(m_rr + k) % NCH]) return (m_rr + k) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] m_ready();
    logic [NCH-1:0] r;
    int t;
    r = '0;
    t = m_target();
    if (rst_n === 1'b1 && (!m_valid || out_ready) && t >= 0) r[t] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int t;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = 0;
      m_ch    = 0;
      m_rr    = NCH - 1;
      m_lock  = 1'b0;
      m_last  = 1'b0;
    end else if (!m_valid || out_ready) begin
      t = m_target();
      if (t >= 0 && in_valid[t]) begin
        m_valid = 1'b1;
        m_data  = int'(in_data[t*WIDTH +: WIDTH]);
        m_ch    = t;
        if (mode) m_rr = t;
`ifdef MUX_BURST_EN
        m_last    = in_last[t];
        m_lock    = !in_last[t];
        m_lock_ch = t;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model out_valid", 32'(out_valid), 32'(m_valid));
    check("model out_data", 32'(out_data), 32'(m_data));
    check("model out_ch", 32'(out_ch), 32'(m_ch));
    check("model in_ready", 32'(in_ready), 32'(m_ready()));
`ifdef MUX_BURST_EN
    check("model out_last", 32'(out_last), 32'(m_last));
`endif
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [NCH-1:0] tv_valid [12] = '{4'b1111, 4'b0110, 4'b0000, 4'b1001, 4'b1111, 4'b0100,
                                    4'b1110, 4'b0011, 4'b1111, 4'b0000, 4'b1010, 4'b0101};
  logic           tv_ready [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                    1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = '0;
    in_valid  = '1;
    in_last   = '1;
    out_ready = 1'b1;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};

    // Reset held with every channel valid
    step();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'h00);
    check("reset out_ch", 32'(out_ch), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'b0000);
    step();
    rst_n = 1'b1;

    // Round-robin rotation over all four channels
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr rotate out_ch", 32'(out_ch), 32'(i % 4));
      check("rr rotate out_data", 32'(out_data), 32'(8'h10 + i % 4));
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr alternate out_ch", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Manual select, then an out-of-range select
    mode     = 1'b0;
    sel      = 3'd2;
    in_valid = 4'b1111;
    in_data[2*WIDTH +: WIDTH] = 8'hA5;
    #1;
    check("manual in_ready", 32'(in_ready), 32'b0100);
    step();
    check("manual out_data", 32'(out_data), 32'hA5);
    check("manual out_ch", 32'(out_ch), 32'd2);
    sel = 3'd7;
    #1;
    check("sel oob in_ready", 32'(in_ready), 32'b0000);
    step();
    check("sel oob out_valid", 32'(out_valid), 32'd0);

    // Backpressure, then release with no bubble
    sel      = 3'd0;
    in_valid = 4'b0001;
    in_data[0 +: WIDTH] = 8'h3C;
    step();
    check("bp load out_data", 32'(out_data), 32'h3C);
    out_ready = 1'b0;
    sel       = 3'd1;
    in_valid  = 4'b0010;
    in_data[1*WIDTH +: WIDTH] = 8'h77;
    #1;
    check("bp in_ready", 32'(in_ready), 32'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp hold out_data", 32'(out_data), 32'h3C);
      check("bp hold out_valid", 32'(out_valid), 32'd1);
      check("bp hold in_ready", 32'(in_ready), 32'b0000);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(in_ready), 32'b0010);
    step();
    check("bp next out_data", 32'(out_data), 32'h77);
    check("bp next out_valid", 32'(out_valid), 32'd1);

    // Mixed valid/ready traffic in round-robin, checked by the model
    mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid  = tv_valid[i];
      out_ready = tv_ready[i];
      step();
    end

    // Reset pulse while a beat is held
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    step();
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post reset out_ch", 32'(out_ch), 32'd0);
    check("post reset out_valid", 32'(out_valid), 32'd1);

`ifdef MUX_BURST_EN
    in_valid = 4'b1000;
    step();
    check("pre-burst out_ch", 32'(out_ch), 32'd3);
    in_valid = 4'b0011;
    in_last  = 4'b1110;
    step();
    check("burst beat0 out_ch", 32'(out_ch), 32'd0);
    check("burst beat0 out_last", 32'(out_last), 32'd0);
    step();
    check("burst beat1 out_ch", 32'(out_ch), 32'd0);
    check("burst beat1 out_last", 32'(out_last), 32'd0);
    in_last = 4'b1111;
    step();
    check("burst beat2 out_ch", 32'(out_ch), 32'd0);
    check("burst beat2 out_last", 32'(out_last), 32'd1);
    step();
    check("after burst out_ch", 32'(out_ch), 32'd1);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
